// File: rtl/adc_packetiser_mc.sv
// adc_packetiser_mc: buffers multi-channel ADC sample sets and emits them as
// byte-stream packets (4-byte header, 16-bit big-endian samples, XOR trailer)
// over a ready/valid interface.
module adc_packetiser_mc #(
    parameter int unsigned SAMPLE_W        = 14,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned SAMPLES_PER_PKT = 32,
    parameter int unsigned FIFO_DEPTH      = 64
) (
    input  logic                       wr_clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       adc_valid,
    input  logic                       flush,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [1:0]                 packetiser_state,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [15:0]                drop_count
);
    localparam int unsigned SET_W = NUM_CH * SAMPLE_W;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]  LAST_CH = 8'(NUM_CH - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeader  = 2'd1,
        StPayload = 2'd2,
        StTrailer = 2'd3
    } state_e;

    logic [SET_W-1:0]    mem_q [2**AW];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]       occ_q;
    logic [15:0]         drop_q;
    logic                push, pop, xfer;

    state_e              state_q, state_d;
    logic [1:0]          hdr_q, hdr_d;
    logic [7:0]          ch_q, ch_d;
    logic                lsb_q, lsb_d;
    logic [7:0]          set_q, set_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          seq_q, seq_d;

    logic [SET_W-1:0]    head;
    logic [SAMPLE_W-1:0] sample_raw;
    logic [15:0]         sample;
    logic [7:0]          cur_byte;

    assign fifo_empty       = (occ_q == '0);
    assign fifo_full        = (occ_q == OW'(FIFO_DEPTH));
    assign drop_count       = drop_q;
    assign push             = adc_valid & ~fifo_full;
    assign out_valid        = (state_q != StIdle);
    assign out_last         = (state_q == StTrailer);
    assign out_data         = cur_byte;
    assign packetiser_state = state_q;
    assign xfer             = out_valid & out_ready;
    // The oldest set leaves the buffer once its final byte is taken.
    assign pop = xfer & (state_q == StPayload) & lsb_q & (ch_q == LAST_CH);

    // Sample storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge wr_clk) begin
        if (push) mem_q[wr_ptr_q] <= adc_data;
    end

    // Buffer pointers, occupancy and saturating overflow counter.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
            if (adc_valid && fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Select the current channel of the oldest set and zero-extend it.
    always_comb begin
        sample_raw = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ch_q == 8'(k)) sample_raw = head[k*SAMPLE_W +: SAMPLE_W];
        end
        sample = 16'(sample_raw);
    end

    // Byte currently offered downstream; held by the registers during stalls.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            StHeader: begin
                case (hdr_q)
                    2'd0:    cur_byte = 8'hA5;
                    2'd1:    cur_byte = seq_q;
                    2'd2:    cur_byte = 8'(NUM_CH);
                    default: cur_byte = cnt_q;
                endcase
            end
            StPayload: cur_byte = lsb_q ? sample[7:0] : sample[15:8];
            StTrailer: cur_byte = csum_q;
            default:   cur_byte = 8'h00;
        endcase
    end

    // Packet sequencing: next state, byte position and running checksum.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        ch_d    = ch_q;
        lsb_d   = lsb_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        seq_d   = seq_q;
        case (state_q)
            StIdle: begin
                if (occ_q >= OW'(SAMPLES_PER_PKT)) begin
                    state_d = StHeader;
                    cnt_d   = 8'(SAMPLES_PER_PKT);
                end else if (flush && !fifo_empty) begin
                    state_d = StHeader;
                    cnt_d   = 8'(occ_q);
                end
                hdr_d  = 2'd0;
                csum_d = 8'h00;
            end
            StHeader: begin
                if (xfer) begin
                    csum_d = csum_q ^ cur_byte;
                    if (hdr_q == 2'd3) begin
                        state_d = StPayload;
                        ch_d    = 8'd0;
                        lsb_d   = 1'b0;
                        set_d   = 8'd0;
                    end else begin
                        hdr_d = hdr_q + 2'd1;
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    csum_d = csum_q ^ cur_byte;
                    if (!lsb_q) begin
                        lsb_d = 1'b1;
                    end else begin
                        lsb_d = 1'b0;
                        if (ch_q == LAST_CH) begin
                            ch_d = 8'd0;
                            if (set_q == cnt_q - 8'd1) state_d = StTrailer;
                            else set_d = set_q + 8'd1;
                        end else begin
                            ch_d = ch_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                if (xfer) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Packet sequencer registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hdr_q   <= 2'd0;
            ch_q    <= 8'd0;
            lsb_q   <= 1'b0;
            set_q   <= 8'd0;
            cnt_q   <= 8'd0;
            csum_q  <= 8'd0;
            seq_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            ch_q    <= ch_d;
            lsb_q   <= lsb_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            seq_q   <= seq_d;
        end
    end

endmodule

// File: tb/tb_adc_packetiser_mc.sv
// Bench for adc_packetiser_mc: a queue-based packet model checked every cycle,
// plus literal expectations for the reference scenarios.
`timescale 1ns/1ps
module tb_adc_packetiser_mc;
    localparam int SW    = 14;
    localparam int NC    = 2;
    localparam int SPP   = 32;
    localparam int DEPTH = 64;
    localparam int SETW  = SW * NC;

    typedef logic [SETW-1:0] set_t;

    logic        wr_clk = 1'b0;
    logic        rst_n  = 1'b0;
    set_t        adc_data;
    logic        adc_valid, flush, out_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_last, fifo_empty, fifo_full;
    logic [1:0]  packetiser_state;
    logic [15:0] drop_count;

    // Small single-channel instance for the two-set reference packet.
    logic [13:0] b_adc_data;
    logic        b_adc_valid, b_flush, b_out_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_last, b_fifo_empty, b_fifo_full;
    logic [1:0]  b_state;
    logic [15:0] b_drop;

    always #5 wr_clk = ~wr_clk;

    adc_packetiser_mc #(.SAMPLE_W(SW), .NUM_CH(NC), .SAMPLES_PER_PKT(SPP), .FIFO_DEPTH(DEPTH)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .packetiser_state(packetiser_state), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .drop_count(drop_count)
    );

    adc_packetiser_mc #(.SAMPLE_W(14), .NUM_CH(1), .SAMPLES_PER_PKT(2), .FIFO_DEPTH(4)) dut_b (
        .wr_clk(wr_clk), .rst_n(rst_n), .adc_data(b_adc_data), .adc_valid(b_adc_valid),
        .flush(b_flush), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .packetiser_state(b_state),
        .fifo_empty(b_fifo_empty), .fifo_full(b_fifo_full), .drop_count(b_drop)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    set_t       m_fifo[$];
    logic [7:0] m_pkt[$];
    int         m_idx  = 0;
    bit         m_busy = 0;
    int         m_seq  = 0;
    int         m_drop = 0;

    task automatic model_start(input int cnt);
        logic [7:0]    x;
        set_t          tmp;
        set_t          mask;
        logic [15:0]   s16;
        logic [31:0]   sq;
        m_pkt.delete();
        sq   = m_seq;
        mask = set_t'((1 << SW) - 1);
        m_pkt.push_back(8'hA5);
        m_pkt.push_back(sq[7:0]);
        m_pkt.push_back(8'(NC));
        m_pkt.push_back(8'(cnt));
        for (int i = 0; i < cnt; i++) begin
            for (int ch = 0; ch < NC; ch++) begin
                tmp = (m_fifo[i] >> (ch * SW)) & mask;
                s16 = 16'(tmp[SW-1:0]);
                m_pkt.push_back(s16[15:8]);
                m_pkt.push_back(s16[7:0]);
            end
        end
        x = 8'h00;
        foreach (m_pkt[i]) x = x ^ m_pkt[i];
        m_pkt.push_back(x);
        m_idx  = 0;
        m_busy = 1;
    endtask

    task automatic model_edge();
        int occ, p, cnt;
        bit full, do_pop;
        occ    = m_fifo.size();
        full   = (occ == DEPTH);
        do_pop = 0;
        if (m_busy) begin
            if (out_ready) begin
                p = m_idx - 4;
                if (p >= 0 && p < m_pkt.size() - 5 && (p % (2 * NC)) == 2 * NC - 1) do_pop = 1;
                if (m_idx == m_pkt.size() - 1) begin
                    m_busy = 0;
                    m_seq  = (m_seq + 1) % 256;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            cnt = 0;
            if (occ >= SPP) cnt = SPP;
            else if (flush && occ > 0) cnt = occ;
            if (cnt > 0) model_start(cnt);
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (adc_valid) begin
            if (full) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_fifo.push_back(adc_data);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge wr_clk or negedge rst_n);
            if (!rst_n) begin
                m_fifo.delete();
                m_pkt.delete();
                m_busy = 0;
                m_idx  = 0;
                m_seq  = 0;
                m_drop = 0;
            end else begin
                model_edge();
            end
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    logic [7:0] got_q[$];
    int         start_log[$];
    logic [7:0] seq_log[$];
    logic [7:0] cnt_log[$];
    int         lens[$];
    int         pkt_cnt = 0;

    initial begin
        logic [7:0] pd, xacc, cur_cnt;
        logic       pl;
        bit         stall;
        int         pos, exp_state;
        stall = 0; pos = 0; pd = 0; pl = 0; xacc = 0; cur_cnt = 0;
        forever begin
            @(negedge wr_clk);
            if (!m_busy) exp_state = 0;
            else if (m_idx < 4) exp_state = 1;
            else if (m_idx == m_pkt.size() - 1) exp_state = 3;
            else exp_state = 2;
            check("out_valid", out_valid, m_busy);
            check("state", packetiser_state, exp_state);
            check("out_last", out_last, (m_busy && m_idx == m_pkt.size() - 1) ? 1 : 0);
            check("fifo_empty", fifo_empty, (m_fifo.size() == 0) ? 1 : 0);
            check("fifo_full", fifo_full, (m_fifo.size() == DEPTH) ? 1 : 0);
            check("drop_count", drop_count, m_drop);
            if (m_busy) check("out_data", out_data, m_pkt[m_idx]);
            if (!rst_n) check("out_data_in_reset", out_data, 0);
            if (stall && out_valid) begin
                check("stall_data", out_data, pd);
                check("stall_last", out_last, pl);
            end
            stall = rst_n && out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (!rst_n) begin
                pos = 0;
            end else if (out_valid && out_ready) begin
                pos++;
                if (pos == 1) begin
                    start_log.push_back(got_q.size());
                    xacc = 8'h00;
                end
                got_q.push_back(out_data);
                xacc = xacc ^ out_data;
                if (pos == 2) seq_log.push_back(out_data);
                if (pos == 4) begin
                    cnt_log.push_back(out_data);
                    cur_cnt = out_data;
                end
                if (out_last) begin
                    check("pkt_xor_zero", xacc, 0);
                    check("pkt_len", pos, 5 + 2 * NC * int'(cur_cnt));
                    lens.push_back(pos);
                    pkt_cnt++;
                    pos = 0;
                end
            end
        end
    end

    // Capture of the single-channel instance.
    logic [7:0] b_got[$];
    int         b_last_idx = -1;
    int         b_last_cnt = 0;

    initial begin
        forever begin
            @(negedge wr_clk);
            if (rst_n && b_out_valid && b_out_ready) begin
                b_got.push_back(b_out_data);
                if (b_out_last) begin
                    b_last_idx = b_got.size() - 1;
                    b_last_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic push_set(input set_t d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    function automatic set_t mkset(input int i, input int salt);
        logic [SW-1:0] c0, c1;
        c0 = SW'(32'h0100 + i * 3 + salt);
        c1 = SW'(32'h3E00 + i * 5 + salt);
        return {c1, c0};
    endfunction

    task automatic wait_pkts(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pkt_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, (pkt_cnt >= target) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] b_exp [9] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA2};
    logic [15:0] rdy_pat = 16'b1101_1110_1011_0111;

    initial begin
        int base, s1, s2, sidx, n, cyc, pushed;
        adc_data = '0; adc_valid = 0; flush = 0; out_ready = 1;
        b_adc_data = '0; b_adc_valid = 0; b_flush = 0; b_out_ready = 1;

        // Reset values.
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_state", packetiser_state, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_drop", drop_count, 0);
        rst_n = 1;
        tick();

        // Two-set single-channel packet.
        b_adc_data = 14'h0102; b_adc_valid = 1; tick();
        b_adc_data = 14'h0304; tick();
        b_adc_valid = 0;
        repeat (20) tick();
        check("b_len", b_got.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < b_got.size()) check("b_byte", b_got[i], b_exp[i]);
        end
        check("b_last_idx", b_last_idx, 8);
        check("b_last_cnt", b_last_cnt, 1);
        check("b_empty", b_fifo_empty, 1);
        check("b_full", b_fifo_full, 0);
        check("b_drop", b_drop, 0);

        // Five sets then flush: partial packet; flush on empty buffer does nothing.
        for (int i = 0; i < 5; i++) push_set(mkset(i, 1));
        tick();
        flush = 1; tick(); flush = 0;
        wait_pkts(1, 200, "flush_pkt_done");
        check("flush_len", lens[0], 25);
        check("flush_count", cnt_log[0], 8'h05);
        check("flush_sof", got_q[0], 8'hA5);
        check("flush_seq", seq_log[0], 8'h00);
        flush = 1; tick(); flush = 0;
        repeat (10) tick();
        check("flush_empty_nopkt", pkt_cnt, 1);
        check("flush_empty_idle", out_valid, 0);

        // Overflow while stalled: 64 stored, 3 dropped, oldest 32 form packet one.
        out_ready = 0;
        for (int i = 0; i < 67; i++) push_set(mkset(i, 7));
        check("ovf_full", fifo_full, 1);
        check("ovf_drop", drop_count, 3);
        check("ovf_hold_data", out_data, 8'hA5);
        out_ready = 1;
        wait_pkts(3, 800, "ovf_pkts_done");
        s1 = start_log[1];
        s2 = start_log[2];
        check("ovf_p1_s0_b0", got_q[s1 + 4], 8'h01);
        check("ovf_p1_s0_b1", got_q[s1 + 5], 8'h07);
        check("ovf_p1_s0_b2", got_q[s1 + 6], 8'h3E);
        check("ovf_p1_s0_b3", got_q[s1 + 7], 8'h07);
        check("ovf_p1_s31_b1", got_q[s1 + 4 + 31 * 4 + 1], 8'h64);
        check("ovf_p1_s31_b3", got_q[s1 + 4 + 31 * 4 + 3], 8'hA2);
        check("ovf_p2_s32_b1", got_q[s2 + 5], 8'h67);
        check("ovf_p2_s32_b3", got_q[s2 + 7], 8'hA7);
        check("ovf_drained", fifo_empty, 1);

        // Three packets under a toggling out_ready pattern.
        base = pkt_cnt;
        cyc = 0; pushed = 0;
        while (pkt_cnt < base + 3 && cyc < 4000) begin
            out_ready = rdy_pat[cyc % 16];
            if (pushed < 96 && cyc % 6 == 0) begin
                adc_data = mkset(pushed, 3);
                adc_valid = 1;
                pushed++;
            end else begin
                adc_valid = 0;
            end
            tick();
            cyc++;
        end
        adc_valid = 0;
        out_ready = 1;
        check("stall_pkts_done", (pkt_cnt >= base + 3) ? 1 : 0, 1);
        check("stall_seq0", seq_log[base], 8'h03);
        check("stall_seq1", seq_log[base + 1], 8'h04);
        check("stall_seq2", seq_log[base + 2], 8'h05);
        repeat (5) tick();

        // Reset in the middle of a payload.
        for (int i = 0; i < 32; i++) push_set(mkset(i, 9));
        n = 0;
        while (packetiser_state != 2'd2 && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_in_payload", packetiser_state, 2);
        repeat (3) tick();
        @(posedge wr_clk);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_last", out_last, 0);
        check("rst_mid_state", packetiser_state, 0);
        check("rst_mid_empty", fifo_empty, 1);
        check("rst_mid_drop", drop_count, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        sidx = seq_log.size();
        base = pkt_cnt;
        for (int i = 0; i < 32; i++) push_set(mkset(i, 11));
        wait_pkts(base + 1, 300, "rst_refill_done");
        check("rst_refill_seq", seq_log[sidx], 8'h00);

        // 256 more one-set packets: sequence wraps FF -> 00.
        for (int k = 0; k < 256; k++) begin
            push_set(mkset(k, 5));
            flush = 1; tick(); flush = 0;
            wait_pkts(base + 2 + k, 40, "wrap_pkt_done");
        end
        check("wrap_seq_ff", seq_log[sidx + 255], 8'hFF);
        check("wrap_seq_00", seq_log[sidx + 256], 8'h00);
        check("wrap_len", lens[lens.size() - 1], 9);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_packetiser_mc.md
ADC_PACKETISER_MC -- requirements
Module: adc_packetiser_mc

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 14: bits per ADC sample; legal 1..16.
REQ-002 SHALL have parameter NUM_CH, default 2: channels per sample set; legal 1..255.
REQ-003 SHALL have parameter SAMPLES_PER_PKT, default 32: sample sets per full packet; legal 1..255.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64: sample-set buffer depth; power of 2, >= SAMPLES_PER_PKT.
REQ-005 SHALL have port wr_clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port adc_data, input, NUM_CH*SAMPLE_W: sample set; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-008 SHALL have port adc_valid, input, 1: adc_data valid this cycle.
REQ-009 SHALL have port flush, input, 1: pulse requesting a partial packet.
REQ-010 SHALL have port out_data, output, 8: stream byte.
REQ-011 SHALL have port out_valid, output, 1: out_data valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts byte.
REQ-013 SHALL have port out_last, output, 1: final byte of packet.
REQ-014 SHALL have port packetiser_state, output, 2: IDLE=0, HEADER=1, PAYLOAD=2, TRAILER=3.
REQ-015 SHALL have ports fifo_empty and fifo_full, output, 1 each: occupancy==0 / occupancy==FIFO_DEPTH.
REQ-016 SHALL have port drop_count, output, 16: sample sets discarded on overflow, saturating.

Function
REQ-017 Capture: adc_valid high at edge N with fifo_full low SHALL write the whole set; occupancy +1 visible after edge N.
REQ-018 Overflow: adc_valid with fifo_full high SHALL discard the set and increment drop_count, saturating at 0xFFFF; a same-cycle pop does not admit the write.
REQ-019 Byte transfer SHALL occur only on an edge with out_valid and out_ready both high; out_data and out_last SHALL hold stable while out_valid high and out_ready low.
REQ-020 IDLE -> HEADER SHALL occur when occupancy >= SAMPLES_PER_PKT (count = SAMPLES_PER_PKT), else on flush with occupancy > 0 (count = occupancy); count is snapshotted at transition.
REQ-021 flush SHALL be ignored outside IDLE and when occupancy == 0.
REQ-022 First header byte SHALL present out_valid on the cycle after the IDLE->HEADER edge.
REQ-023 Header SHALL be 4 bytes in order: 0xA5, seq[7:0], NUM_CH[7:0], count[7:0].
REQ-024 Payload SHALL be count sets, oldest first; per set channel 0 first; each sample zero-extended to 16 bits, MSB byte first.
REQ-025 A set SHALL be popped from the buffer on acceptance of its last channel's LSB byte.
REQ-026 Trailer SHALL be one byte: XOR of all header and payload bytes of the packet; out_last high only on this byte.
REQ-027 Packet length SHALL be 5 + 2*NUM_CH*count bytes; out_valid SHALL remain high from the first header byte through the trailer, with no bubbles.
REQ-028 seq SHALL increment by 1 on trailer acceptance, wrapping 255 -> 0.
REQ-029 After trailer acceptance state SHALL return to IDLE; a new packet may start on the next edge if REQ-020 holds.
REQ-030 Capture SHALL continue in all states; simultaneous push and pop leaves occupancy unchanged.

Reset
REQ-031 rst_n low SHALL immediately force out_valid=0, out_last=0, out_data=0, packetiser_state=0, occupancy=0 (fifo_empty=1, fifo_full=0), seq=0, drop_count=0.
REQ-032 Reset mid-packet SHALL abandon the packet without trailer; the first packet after release carries seq 0.
REQ-033 No capture or output SHALL occur while rst_n is low; normal operation begins on the first edge after release.

Verification
REQ-034 NUM_CH=1, SPP=2; sets 0x0102, 0x0304, out_ready=1 -> bytes A5 00 01 02 01 02 03 04 A2, out_last on A2, then fifo_empty=1.
REQ-035 Defaults; 64 sets plus 3 more while out_ready=0 -> fifo_full=1, drop_count=3, first packet holds sets 0..31.
REQ-036 Defaults; 5 sets, then flush -> 25-byte packet, header count 0x05; flush with empty buffer -> no output.
REQ-037 Random out_ready toggling over 3 packets -> out_data/out_last stable during stalls, seq 00,01,02, checksum correct.
REQ-038 rst_n low during PAYLOAD -> outputs zero at once; after refill, next packet seq 00; 257 packets -> seq wraps FF -> 00.
